// File: rtl/frame_sequencer.sv
// Per-frame master for the physics engine: starts the engine, times out a stalled run,
// captures positions, scores points, computes ball/player cover flags and publishes a snapshot.
module frame_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [3:0]  WIN_SCORE   = 4'd7,
  parameter logic [9:0]  BALL_SIZE   = 10'd40,
  parameter logic [9:0]  PLAYER_W    = 10'd64,
  parameter logic [9:0]  PLAYER_H    = 10'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       restart,
  output logic       phys_en,
  input  logic       phys_valid,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  input  logic [9:0] ball_pos_x,
  input  logic [9:0] ball_pos_y,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       p1_cover,
  output logic       p2_cover,
  output logic [9:0] snap_p1_x,
  output logic [9:0] snap_p1_y,
  output logic [9:0] snap_p2_x,
  output logic [9:0] snap_p2_y,
  output logic [9:0] snap_ball_x,
  output logic [9:0] snap_ball_y,
  output logic       snap_valid,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_over,
  output logic       timeout_err,
  output logic [7:0] drop_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CAPTURE, S_COLLIDE, S_PUBLISH
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic [9:0]    r_ball_x, r_ball_y;
  logic [9:0]    r_pl_x [2];
  logic [9:0]    r_pl_y [2];
  logic [9:0]    r_snap_pl_x [2];
  logic [9:0]    r_snap_pl_y [2];
  logic [9:0]    r_snap_ball_x, r_snap_ball_y;
  logic [1:0]    w_cover;
  logic [1:0]    r_cover;
  logic [3:0]    r_p1_score, r_p2_score;
  logic          r_match_over, r_timeout_err;
  logic [7:0]    r_drop_cnt;
  logic          w_phys_en, w_snap_valid;

  // Counter is 0 during START, so the abort lands TIMEOUT_CYC cycles after phys_en.
  assign w_timeout = (r_state == S_WAIT) && !phys_valid && (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_phys_en    = 1'b0;
    w_snap_valid = 1'b0;
    case (r_state)
      S_IDLE:    if (frame_tick && !r_match_over) w_state_next = S_START;
      S_START: begin
        w_phys_en    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (phys_valid)     w_state_next = S_CAPTURE;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_CAPTURE: w_state_next = S_COLLIDE;
      S_COLLIDE: w_state_next = S_PUBLISH;
      S_PUBLISH: begin
        w_snap_valid = 1'b1;
        w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cover
      assign w_cover[gi] = ({1'b0, r_ball_x} < {1'b0, r_pl_x[gi]} + {1'b0, PLAYER_W}) &&
                           ({1'b0, r_ball_x} + {1'b0, BALL_SIZE} > {1'b0, r_pl_x[gi]}) &&
                           ({1'b0, r_ball_y} < {1'b0, r_pl_y[gi]} + {1'b0, PLAYER_H}) &&
                           ({1'b0, r_ball_y} + {1'b0, BALL_SIZE} > {1'b0, r_pl_y[gi]});
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_ball_x      <= '0;
      r_ball_y      <= '0;
      r_pl_x        <= '{default: '0};
      r_pl_y        <= '{default: '0};
      r_snap_pl_x   <= '{default: '0};
      r_snap_pl_y   <= '{default: '0};
      r_snap_ball_x <= '0;
      r_snap_ball_y <= '0;
      r_cover       <= '0;
      r_timeout_err <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      if (r_state == S_IDLE) r_cnt <= '0;
      else if (r_state == S_START || r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
      if (r_state == S_CAPTURE) begin
        r_ball_x  <= ball_pos_x;
        r_ball_y  <= ball_pos_y;
        r_pl_x[0] <= p1_pos_x;
        r_pl_y[0] <= p1_pos_y;
        r_pl_x[1] <= p2_pos_x;
        r_pl_y[1] <= p2_pos_y;
      end
      // Covers and snapshot update together so both are valid during the snap_valid cycle.
      if (r_state == S_COLLIDE) begin
        r_cover       <= w_cover;
        r_snap_ball_x <= r_ball_x;
        r_snap_ball_y <= r_ball_y;
        r_snap_pl_x   <= r_pl_x;
        r_snap_pl_y   <= r_pl_y;
      end
      if (w_timeout) begin
        r_cover       <= '0;
        r_timeout_err <= 1'b1;
      end
      if (frame_tick && r_state != S_IDLE && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_p1_score   <= '0;
      r_p2_score   <= '0;
      r_match_over <= 1'b0;
    end else if (r_state == S_CAPTURE && game_over) begin
      if (winner == 2'd1 && r_p1_score < WIN_SCORE) begin
        r_p1_score <= r_p1_score + 4'd1;
        if (r_p1_score + 4'd1 == WIN_SCORE) r_match_over <= 1'b1;
      end
      if (winner == 2'd2 && r_p2_score < WIN_SCORE) begin
        r_p2_score <= r_p2_score + 4'd1;
        if (r_p2_score + 4'd1 == WIN_SCORE) r_match_over <= 1'b1;
      end
    end
  end

  assign phys_en     = w_phys_en;
  assign snap_valid  = w_snap_valid;
  assign p1_cover    = r_cover[0];
  assign p2_cover    = r_cover[1];
  assign snap_p1_x   = r_snap_pl_x[0];
  assign snap_p1_y   = r_snap_pl_y[0];
  assign snap_p2_x   = r_snap_pl_x[1];
  assign snap_p2_y   = r_snap_pl_y[1];
  assign snap_ball_x = r_snap_ball_x;
  assign snap_ball_y = r_snap_ball_y;
  assign p1_score    = r_p1_score;
  assign p2_score    = r_p2_score;
  assign match_over  = r_match_over;
  assign timeout_err = r_timeout_err;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer; cycle 0 of each run is the cycle frame_tick is first high.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst, frame_tick, restart, phys_valid, game_over;
  logic [1:0] winner;
  logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y, ball_pos_x, ball_pos_y;
  logic       phys_en, p1_cover, p2_cover, snap_valid, match_over, timeout_err;
  logic [9:0] snap_p1_x, snap_p1_y, snap_p2_x, snap_p2_y, snap_ball_x, snap_ball_y;
  logic [3:0] p1_score, p2_score;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_frame call
  int en_cnt, en_cyc, snap_cnt, snap_cyc, to_cyc;
  logic [9:0] s_bx, s_by, s_p1x;

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .phys_en(phys_en), .phys_valid(phys_valid),
    .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .game_over(game_over), .winner(winner),
    .p1_cover(p1_cover), .p2_cover(p2_cover),
    .snap_p1_x(snap_p1_x), .snap_p1_y(snap_p1_y), .snap_p2_x(snap_p2_x), .snap_p2_y(snap_p2_y),
    .snap_ball_x(snap_ball_x), .snap_ball_y(snap_ball_y), .snap_valid(snap_valid),
    .p1_score(p1_score), .p2_score(p2_score), .match_over(match_over),
    .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  task automatic set_pos(input int bx, input int by, input int ax, input int ay,
                         input int cx, input int cy);
    ball_pos_x = 10'(bx); ball_pos_y = 10'(by);
    p1_pos_x = 10'(ax); p1_pos_y = 10'(ay);
    p2_pos_x = 10'(cx); p2_pos_y = 10'(cy);
  endtask

  // Drives ticks every `period` cycles (nticks of them), a 5-cycle engine model, and
  // optional restart/rst pulses; records what the DUT emitted. Called just after a posedge.
  task automatic run_frame(input int period, input int nticks, input int ncyc, input bit engine_on,
                           input bit go, input logic [1:0] win, input int restart_cyc,
                           input int rst_cyc);
    int last_en;
    en_cnt = 0; en_cyc = -1; snap_cnt = 0; snap_cyc = -1; to_cyc = -1;
    s_bx = '0; s_by = '0; s_p1x = '0; last_en = -100;
    game_over = go; winner = win;
    for (int c = 0; c < ncyc; c++) begin
      frame_tick = (c % period == 0) && (c / period < nticks);
      phys_valid = engine_on && (c == last_en + 5);
      restart    = (c == restart_cyc);
      rst        = (c == rst_cyc);
      @(negedge clk);
      if (phys_en) begin
        en_cnt++;
        if (en_cyc < 0) en_cyc = c;
        last_en = c;
      end
      if (snap_valid) begin
        snap_cnt++;
        if (snap_cyc < 0) begin
          snap_cyc = c; s_bx = snap_ball_x; s_by = snap_ball_y; s_p1x = snap_p1_x;
        end
      end
      if (timeout_err && to_cyc < 0) to_cyc = c;
      @(posedge clk); #1;
    end
    frame_tick = 0; phys_valid = 0; restart = 0; rst = 0; game_over = 0; winner = 0;
    $display("frame: en=%0d@%0d snap=%0d@%0d to@%0d p1c=%0b p2c=%0b sc=%0d/%0d mo=%0b drop=%0d",
             en_cnt, en_cyc, snap_cnt, snap_cyc, to_cyc, p1_cover, p2_cover,
             p1_score, p2_score, match_over, drop_cnt);
  endtask

  task automatic do_reset;
    rst = 1; frame_tick = 0; restart = 0; phys_valid = 0; game_over = 0; winner = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if ({phys_en, snap_valid, p1_cover, p2_cover, match_over, timeout_err} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000",
        {phys_en, snap_valid, p1_cover, p2_cover, match_over, timeout_err});
    end
    checks++;
    if ({snap_ball_x, snap_p1_x, snap_p2_y, p1_score, p2_score, drop_cnt} !== 46'd0) begin
      failures++; $display("FAIL reset_values got=%h exp=0",
        {snap_ball_x, snap_p1_x, snap_p2_y, p1_score, p2_score, drop_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    set_pos(100, 100, 80, 150, 500, 400);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL nom_en_cnt got=%0d exp=1", en_cnt); end
    checks++; if (en_cyc !== 1) begin failures++; $display("FAIL nom_en_cyc got=%0d exp=1", en_cyc); end
    checks++; if (snap_cyc !== 9) begin failures++; $display("FAIL nom_snap_cyc got=%0d exp=9", snap_cyc); end
    checks++; if (snap_cnt !== 1) begin failures++; $display("FAIL nom_snap_cnt got=%0d exp=1", snap_cnt); end
    checks++; if (s_bx !== 10'd100 || s_by !== 10'd100 || s_p1x !== 10'd80) begin
      failures++; $display("FAIL nom_snap_pos got=%0d,%0d,%0d exp=100,100,80", s_bx, s_by, s_p1x);
    end
    checks++; if (p1_cover !== 1'b0) begin failures++; $display("FAIL nom_p1_cover_a got=%b exp=0", p1_cover); end
    set_pos(100, 100, 80, 120, 500, 400);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if ({p1_cover, p2_cover} !== 2'b10) begin
      failures++; $display("FAIL nom_cover_b got=%b%b exp=10", p1_cover, p2_cover);
    end
    set_pos(100, 100, 80, 120, 90, 110);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if ({p1_cover, p2_cover} !== 2'b11) begin
      failures++; $display("FAIL nom_cover_both got=%b%b exp=11", p1_cover, p2_cover);
    end
  endtask

  task automatic test_edge_touch;
    set_pos(40, 176, 0, 176, 500, 400);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (p1_cover !== 1'b1) begin failures++; $display("FAIL edge_overlap got=%b exp=1", p1_cover); end
    set_pos(64, 176, 0, 176, 500, 400);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (p1_cover !== 1'b0) begin failures++; $display("FAIL edge_touch got=%b exp=0", p1_cover); end
  endtask

  task automatic test_scoring;
    set_pos(300, 300, 0, 0, 600, 400);
    for (int i = 1; i <= 7; i++) begin
      run_frame(1, 1, 14, 1, 1, 2'd1, -1, -1);
      checks++; if (p1_score !== 4'(i)) begin
        failures++; $display("FAIL score_p1_step got=%0d exp=%0d", p1_score, i);
      end
      checks++; if (match_over !== (i == 7)) begin
        failures++; $display("FAIL score_match_over got=%b exp=%b", match_over, (i == 7));
      end
    end
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (en_cnt !== 0) begin failures++; $display("FAIL over_no_start got=%0d exp=0", en_cnt); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL over_no_drop got=%0d exp=0", drop_cnt); end
    run_frame(1, 0, 2, 0, 0, 2'd0, 0, -1);
    checks++; if ({p1_score, match_over} !== 5'd0) begin
      failures++; $display("FAIL restart_clear got=%0d,%b exp=0,0", p1_score, match_over);
    end
    run_frame(1, 1, 14, 1, 1, 2'd2, -1, -1);
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL restart_start got=%0d exp=1", en_cnt); end
    checks++; if (p2_score !== 4'd1 || p1_score !== 4'd0) begin
      failures++; $display("FAIL score_p2 got=%0d,%0d exp=0,1", p1_score, p2_score);
    end
    run_frame(1, 1, 14, 1, 1, 2'd3, -1, -1);
    checks++; if (p2_score !== 4'd1 || p1_score !== 4'd0) begin
      failures++; $display("FAIL score_w3 got=%0d,%0d exp=0,1", p1_score, p2_score);
    end
    // Restart lands on the CAPTURE cycle (cycle 7) of a scoring frame.
    run_frame(1, 1, 14, 1, 1, 2'd1, 7, -1);
    checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin
      failures++; $display("FAIL restart_wins got=%0d,%0d exp=0,0", p1_score, p2_score);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_pos(100, 100, 80, 120, 500, 400);
    run_frame(4, 6, 30, 1, 0, 2'd0, -1, -1);
    checks++; if (en_cnt !== 2) begin failures++; $display("FAIL overrun_en got=%0d exp=2", en_cnt); end
    checks++; if (snap_cnt !== 2) begin failures++; $display("FAIL overrun_snap got=%0d exp=2", snap_cnt); end
    checks++; if (drop_cnt !== 8'd4) begin failures++; $display("FAIL overrun_drop got=%0d exp=4", drop_cnt); end
    run_frame(1, 300, 310, 1, 0, 2'd0, -1, -1);
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
    checks++; if (en_cnt !== 30) begin failures++; $display("FAIL sat_en got=%0d exp=30", en_cnt); end
  endtask

  task automatic test_timeout;
    set_pos(100, 100, 80, 120, 500, 400);
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (p1_cover !== 1'b1) begin failures++; $display("FAIL to_pre_cover got=%b exp=1", p1_cover); end
    run_frame(1, 1, 25, 0, 0, 2'd0, -1, -1);
    checks++; if (to_cyc !== 17) begin failures++; $display("FAIL to_cycle got=%0d exp=17", to_cyc); end
    checks++; if (snap_cnt !== 0) begin failures++; $display("FAIL to_no_snap got=%0d exp=0", snap_cnt); end
    checks++; if ({p1_cover, p2_cover} !== 2'b00) begin
      failures++; $display("FAIL to_cover_clr got=%b%b exp=00", p1_cover, p2_cover);
    end
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (en_cnt !== 1 || snap_cyc !== 9) begin
      failures++; $display("FAIL to_recover got=%0d,%0d exp=1,9", en_cnt, snap_cyc);
    end
    checks++; if (timeout_err !== 1'b1 || p1_cover !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b,%b exp=1,1", timeout_err, p1_cover);
    end
  endtask

  task automatic test_reset_mid_wait;
    set_pos(200, 200, 180, 190, 500, 400);
    run_frame(1, 1, 15, 1, 0, 2'd0, -1, 4);
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL rmw_en got=%0d exp=1", en_cnt); end
    checks++; if (snap_cnt !== 0) begin failures++; $display("FAIL rmw_no_snap got=%0d exp=0", snap_cnt); end
    checks++; if ({timeout_err, p1_cover, p2_cover, match_over} !== 4'b0) begin
      failures++; $display("FAIL rmw_flags got=%b%b%b%b exp=0000", timeout_err, p1_cover, p2_cover, match_over);
    end
    checks++; if (drop_cnt !== 8'd0 || snap_ball_x !== 10'd0 || snap_p1_x !== 10'd0) begin
      failures++; $display("FAIL rmw_values got=%0d,%0d,%0d exp=0,0,0", drop_cnt, snap_ball_x, snap_p1_x);
    end
    run_frame(1, 1, 14, 1, 0, 2'd0, -1, -1);
    checks++; if (snap_cyc !== 9 || s_bx !== 10'd200) begin
      failures++; $display("FAIL rmw_after got=%0d,%0d exp=9,200", snap_cyc, s_bx);
    end
  endtask

  initial begin
    set_pos(0, 0, 0, 0, 0, 0);
    test_reset();
    test_nominal();
    test_edge_touch();
    test_scoring();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
